// File: rtl/mem_stage.sv
// Memory stage: Execute-Memory register plus req/ack data-memory access FSM feeding register_MW.
// Latency: non-memory op commits the cycle after capture; memory op takes ACCESS cycles (>=1) then one COMMIT cycle.
// Backpressure: StallM holds fetch/decode/execute while a request is outstanding; en=0 freezes everything.
//
// Ports:
//   clk, rst (async active-low), en (global enable)
//   *E inputs      : instruction fields from execute, captured when StallM=0
//   mem_req/mem_we/mem_addr/mem_wdata : data-memory request, held until mem_ack or timeout
//   mem_ack/mem_rdata                 : data-memory completion and load data
//   PCSrcM/RegWriteM/MemtoRegM        : controls to register_MW, only high on a commit cycle
//   ReadDataM/ALUOutM/WA3M            : data to register_MW
//   StallM : upstream hold; mem_err : sticky memory-timeout flag
module mem_stage #(
    parameter int N       = 24,
    parameter int TIMEOUT = 16,
    parameter int A       = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         PCSrcE,
    input  logic         RegWriteE,
    input  logic         MemtoRegE,
    input  logic         MemWriteE,
    input  logic [N-1:0] ALUResultE,
    input  logic [N-1:0] WriteDataE,
    input  logic [A-1:0] WA3E,
    input  logic         mem_ack,
    input  logic [N-1:0] mem_rdata,
    output logic         mem_req,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    output logic         PCSrcM,
    output logic         RegWriteM,
    output logic         MemtoRegM,
    output logic [N-1:0] ReadDataM,
    output logic [N-1:0] ALUOutM,
    output logic [A-1:0] WA3M,
    output logic         StallM,
    output logic         mem_err
);

    localparam int CW = $clog2(TIMEOUT);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    // Execute-Memory register
    logic         em_valid;
    logic         em_pcsrc;
    logic         em_regwrite;
    logic         em_memtoreg;
    logic         em_memwrite;
    logic [N-1:0] em_alu;
    logic [N-1:0] em_wdata;
    logic [A-1:0] em_wa3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [N-1:0]  rdata_q;
    logic          err_q;

    logic memop;
    logic commit;
    logic in_access;

    assign memop     = em_valid & (em_memtoreg | em_memwrite);
    assign in_access = (state == S_ACCESS);

    // A memory op only commits from COMMIT; a non-memory op commits straight out of IDLE.
    assign commit = ((state == S_IDLE) & em_valid & ~memop) | (state == S_COMMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            em_valid    <= 1'b0;
            em_pcsrc    <= 1'b0;
            em_regwrite <= 1'b0;
            em_memtoreg <= 1'b0;
            em_memwrite <= 1'b0;
            em_alu      <= '0;
            em_wdata    <= '0;
            em_wa3      <= '0;
            state       <= S_IDLE;
            cnt         <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else if (en) begin
            case (state)
                S_ACCESS: begin
                    // EM register holds while the request is outstanding
                    if (mem_ack) begin
                        state <= S_COMMIT;
                        if (em_memtoreg) begin
                            rdata_q <= mem_rdata;
                        end
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        // Forced completion: the pipeline moves on with zero load data
                        state   <= S_COMMIT;
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    // IDLE or COMMIT: StallM is low, so the next instruction is captured
                    // on this same edge, giving back-to-back memops without a gap.
                    em_valid    <= 1'b1;
                    em_pcsrc    <= PCSrcE;
                    em_regwrite <= RegWriteE;
                    em_memtoreg <= MemtoRegE;
                    em_memwrite <= MemWriteE;
                    em_alu      <= ALUResultE;
                    em_wdata    <= WriteDataE;
                    em_wa3      <= WA3E;
                    if (MemtoRegE | MemWriteE) begin
                        state <= S_ACCESS;
                        cnt   <= '0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign mem_req   = in_access;
    assign mem_we    = in_access & em_memwrite;
    assign mem_addr  = in_access ? em_alu   : '0;
    assign mem_wdata = in_access ? em_wdata : '0;
    assign StallM    = in_access;

    assign PCSrcM    = em_pcsrc    & commit;
    assign RegWriteM = em_regwrite & commit;
    assign MemtoRegM = em_memtoreg & commit;
    assign ReadDataM = rdata_q;
    assign ALUOutM   = em_alu;
    assign WA3M      = em_wa3;
    assign mem_err   = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: instruction-level reference model with a commit scoreboard.
// Latency: model predicts stall length from the memory wait it chooses per access.
// Backpressure: instructions are held on the E inputs until the model says they are taken.
module tb_mem_stage;

    localparam int N  = 24;
    localparam int TO = 16;
    localparam int A  = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         PCSrcE, RegWriteE, MemtoRegE, MemWriteE;
    logic [N-1:0] ALUResultE, WriteDataE;
    logic [A-1:0] WA3E;
    logic         mem_ack;
    logic [N-1:0] mem_rdata;
    logic         mem_req, mem_we;
    logic [N-1:0] mem_addr, mem_wdata;
    logic         PCSrcM, RegWriteM, MemtoRegM;
    logic [N-1:0] ReadDataM, ALUOutM;
    logic [A-1:0] WA3M;
    logic         StallM, mem_err;

    always #5 clk = ~clk;

    mem_stage #(.N(N), .TIMEOUT(TO), .A(A)) dut (
        .clk(clk), .rst(rst), .en(en),
        .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .WA3E(WA3E),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .ReadDataM(ReadDataM), .ALUOutM(ALUOutM), .WA3M(WA3M),
        .StallM(StallM), .mem_err(mem_err)
    );

    typedef struct packed {
        logic         pc, rw, mtr, mw;
        logic [N-1:0] alu, wd;
        logic [A-1:0] wa;
    } ins_t;

    typedef struct packed {
        logic         pc, rw, mtr;
        logic [N-1:0] alu;
        logic [A-1:0] wa;
        logic [N-1:0] rd;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;

    // Reference model: an access lasts (wait+1) cycles, or TO cycles if never acked.
    int           stall_left;
    int           acc_tot;
    int           acc_w;
    logic         acc_we, acc_vis;
    logic [N-1:0] acc_addr, acc_wdata, acc_rdata;
    logic         exp_vis;
    logic [N-1:0] m_rd;
    logic         m_err;
    int           nxt_w;
    logic [N-1:0] nxt_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic model_reset;
        stall_left = 0; acc_tot = 0; acc_w = 0;
        acc_we = 0; acc_vis = 0; acc_addr = '0; acc_wdata = '0; acc_rdata = '0;
        exp_vis = 0; m_rd = '0; m_err = 0;
        sb.delete();
    endtask

    task automatic drive_idle;
        en = 0; PCSrcE = 0; RegWriteE = 0; MemtoRegE = 0; MemWriteE = 0;
        ALUResultE = '0; WriteDataE = '0; WA3E = '0; mem_ack = 0; mem_rdata = '0;
    endtask

    // One clock: check combinational outputs, drive inputs, advance model at the edge.
    task automatic step(input logic en_v, input ins_t ins, output bit acc);
        logic req_e;
        logic vis;
        int   k;
        req_e = (stall_left > 0);
        k     = acc_tot - stall_left;
        chk("StallM",    StallM,    req_e);
        chk("mem_req",   mem_req,   req_e);
        chk("mem_we",    mem_we,    req_e & acc_we);
        chk("mem_addr",  mem_addr,  req_e ? acc_addr  : '0);
        chk("mem_wdata", mem_wdata, req_e ? acc_wdata : '0);
        chk("commit_visible", PCSrcM | RegWriteM | MemtoRegM, exp_vis);
        en = en_v;
        PCSrcE = ins.pc; RegWriteE = ins.rw; MemtoRegE = ins.mtr; MemWriteE = ins.mw;
        ALUResultE = ins.alu; WriteDataE = ins.wd; WA3E = ins.wa;
        if (req_e && k == acc_w) begin
            mem_ack = 1; mem_rdata = acc_rdata;
        end else if (req_e) begin
            mem_ack = 0; mem_rdata = N'($urandom);
        end else begin
            mem_ack = 1'($urandom_range(0, 1)); mem_rdata = N'($urandom);
        end
        @(posedge clk);
        acc = 0;
        if (en_v) begin
            if (stall_left > 0) begin
                stall_left--;
                exp_vis = (stall_left == 0) ? acc_vis : 1'b0;
            end else begin
                acc = 1;
                vis = ins.pc | ins.rw | ins.mtr;
                if (ins.mtr | ins.mw) begin
                    acc_w      = nxt_w;
                    acc_tot    = (nxt_w < TO) ? nxt_w + 1 : TO;
                    stall_left = acc_tot;
                    acc_we     = ins.mw;
                    acc_addr   = ins.alu;
                    acc_wdata  = ins.wd;
                    acc_rdata  = nxt_rdata;
                    acc_vis    = vis;
                    if (nxt_w >= TO) begin
                        m_rd  = '0;
                        m_err = 1;
                    end else if (ins.mtr) begin
                        m_rd = nxt_rdata;
                    end
                    exp_vis = 0;
                end else begin
                    exp_vis = vis;
                end
                if (vis) sb.push_back('{ins.pc, ins.rw, ins.mtr, ins.alu, ins.wa, m_rd, m_err});
            end
        end
        @(negedge clk);
    endtask

    task automatic issue(input ins_t ins, input int w, input logic [N-1:0] rd, input int en_pct);
        bit a;
        int guard;
        guard = 0;
        nxt_w = w; nxt_rdata = rd;
        do begin
            step(($urandom_range(0, 99) < en_pct), ins, a);
            guard++;
        end while (!a && guard < 200);
        if (!a) begin
            vectors++; errors++;
            $display("FAIL issue_accept: instruction not taken after %0d cycles, expected acceptance", guard);
        end
    endtask

    task automatic bubbles(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(1'b1, '0, a);
    endtask

    task automatic do_reset;
        drive_idle();
        rst = 0;
        @(negedge clk);
        model_reset();
        chk("rst_mem_req", mem_req, 0);     chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);   chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_PCSrcM", PCSrcM, 0);       chk("rst_RegWriteM", RegWriteM, 0);
        chk("rst_MemtoRegM", MemtoRegM, 0); chk("rst_ReadDataM", ReadDataM, 0);
        chk("rst_ALUOutM", ALUOutM, 0);     chk("rst_WA3M", WA3M, 0);
        chk("rst_StallM", StallM, 0);       chk("rst_mem_err", mem_err, 0);
        rst = 1;
    endtask

    // Scoreboard monitor: one pop per committed, visible instruction on an enabled cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst === 1'b1 && en === 1'b1 && (PCSrcM | RegWriteM | MemtoRegM)) begin
                if (sb.size() == 0) begin
                    vectors++; errors++;
                    $display("FAIL spurious_commit: commit seen (ALUOutM=%0h), expected none", ALUOutM);
                end else begin
                    e = sb.pop_front();
                    chk("cm_PCSrcM", PCSrcM, e.pc);
                    chk("cm_RegWriteM", RegWriteM, e.rw);
                    chk("cm_MemtoRegM", MemtoRegM, e.mtr);
                    chk("cm_ALUOutM", ALUOutM, e.alu);
                    chk("cm_WA3M", WA3M, e.wa);
                    chk("cm_ReadDataM", ReadDataM, e.rd);
                    chk("cm_mem_err", mem_err, e.err);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ins_t ins;
        bit   a;
        int   r, w;
        drive_idle();
        rst = 0;
        model_reset();
        nxt_w = 0; nxt_rdata = '0;
        do_reset();

        // ALU op
        ins = '0; ins.rw = 1; ins.alu = 24'h00002A; ins.wa = 4'd3;
        issue(ins, 0, '0, 100);
        bubbles(1);

        // Load with three ACCESS cycles
        ins = '0; ins.rw = 1; ins.mtr = 1; ins.alu = 24'h000010; ins.wa = 4'd5;
        issue(ins, 2, 24'hABCDEF, 100);
        bubbles(5);

        // Store, zero-wait; commits with RegWriteM=0
        ins = '0; ins.mw = 1; ins.alu = 24'h000020; ins.wd = 24'h123456;
        issue(ins, 0, '0, 100);
        bubbles(3);

        // Back-to-back zero-wait loads
        ins = '0; ins.rw = 1; ins.mtr = 1; ins.alu = 24'h000100; ins.wa = 4'd6;
        issue(ins, 0, 24'h111111, 100);
        ins = '0; ins.rw = 1; ins.mtr = 1; ins.alu = 24'h000104; ins.wa = 4'd7;
        issue(ins, 0, 24'h222222, 100);
        bubbles(4);

        // Load that never gets acked
        ins = '0; ins.rw = 1; ins.mtr = 1; ins.alu = 24'h000200; ins.wa = 4'd8;
        issue(ins, 99, 24'h333333, 100);
        bubbles(TO + 3);
        chk("timeout_mem_err_sticky", mem_err, 1);

        // Random traffic with random enable
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            ins = '0;
            ins.alu = N'($urandom); ins.wd = N'($urandom); ins.wa = A'($urandom);
            case (r)
                0:       ins = '0;
                1, 2, 3: begin ins.rw = 1; ins.pc = 1'($urandom_range(0, 1)); end
                4, 5, 6: begin ins.rw = 1; ins.mtr = 1; end
                7, 8:    begin ins.mw = 1; ins.rw = 1'($urandom_range(0, 1)); ins.pc = 1'($urandom_range(0, 1)); end
                default: begin ins.pc = 1; ins.rw = 1'($urandom_range(0, 1)); end
            endcase
            w = ($urandom_range(0, 19) == 0) ? 40 : $urandom_range(0, 3);
            issue(ins, w, N'($urandom), 85);
        end
        bubbles(TO + 4);
        chk("sb_drained", sb.size(), 0);

        // Asynchronous reset in the middle of an access
        ins = '0; ins.rw = 1; ins.mtr = 1; ins.alu = 24'h000300; ins.wa = 4'd9;
        issue(ins, 10, 24'h444444, 100);
        step(1'b1, '0, a);
        step(1'b1, '0, a);
        chk("pre_reset_mem_req", mem_req, 1);
        #2;
        rst = 0;
        #1;
        chk("async_mem_req", mem_req, 0);
        chk("async_StallM", StallM, 0);
        chk("async_mem_err", mem_err, 0);
        chk("async_ReadDataM", ReadDataM, 0);
        drive_idle();
        @(negedge clk);
        model_reset();
        rst = 1;
        bubbles(2);
        chk("post_reset_mem_err", mem_err, 0);

        // Pipeline works after reset
        ins = '0; ins.rw = 1; ins.mtr = 1; ins.alu = 24'h000400; ins.wa = 4'd10;
        issue(ins, 1, 24'h555555, 100);
        bubbles(4);
        chk("final_sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
